conv_3x3_filter: RTL

- Consumes the three-row pixel column stream from the line buffer and produces one filtered RGB565 pixel per image column.
- Each pixel is produced from its 3x3 neighbourhood using the kernel selected at frame start.
- Sits between the line buffer and the frame-buffer write / downstream processing stage.
- Handles the image border by passing the centre pixel through unchanged.

---
 rtl/conv_3x3_filter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/conv_3x3_filter.sv
// 3x3 neighbourhood filter on RGB565 column beats: identity, gaussian or sharpen.
// Border pixels pass through; the last pixel of each line is flushed on the next free slot.
module conv_3x3_filter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [2:0][15:0] line_buffer_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             data_valid_in,
  input  logic [1:0]       kernel_select_in,
  output logic [15:0]      pixel_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);
  typedef enum logic [1:0] {K_PASS, K_GAUSS, K_SHARP} kind_e;

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]  Y_LAST = 10'(HEIGHT - 1);

  logic [2:0][15:0] win_l_q, win_l_d, win_c_q, win_c_d, win_r_q, win_r_d;
  logic             fill_q, fill_d;
  logic [1:0]       kernel_q, kernel_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_pix_q, pend_pix_d;
  logic [9:0]       pend_y_q, pend_y_d;

  logic             s0_valid_q, s0_valid_d, s0_bypass_q, s0_bypass_d;
  logic [10:0]      s0_x_q, s0_x_d;
  logic [9:0]       s0_y_q, s0_y_d;
  logic [15:0]      s0_pix_q, s0_pix_d;

  logic             s1_valid_q, s1_valid_d;
  kind_e            s1_kind_q, s1_kind_d;
  logic [10:0]      s1_x_q, s1_x_d;
  logic [9:0]       s1_y_q, s1_y_d;
  logic [15:0]      s1_pix_q, s1_pix_d;
  logic [2:0][10:0] s1_sum_q, s1_sum_d;

  logic [15:0]      pixel_q, pixel_d;
  logic [10:0]      hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             valid_q, valid_d;

  logic             accept, win_emit, flush, border;
  logic [5:0]       nw, n, ne, w, c, e, sw, s, se;
  logic [10:0]      gsum, ssum;

  // Channel k of an RGB565 word: 0 blue, 1 green, 2 red (zero-extended to 6 bits).
  function automatic logic [5:0] chan(input logic [15:0] p, input int unsigned k);
    case (k)
      0:       return {1'b0, p[4:0]};
      1:       return p[10:5];
      default: return {1'b0, p[15:11]};
    endcase
  endfunction

  function automatic logic [5:0] clamp(input logic [10:0] v, input logic [5:0] hi);
    if (v[10])                return '0;
    else if (v > {5'b0, hi})  return hi;
    else                      return v[5:0];
  endfunction

  always_comb begin
    win_l_d    = win_l_q;
    win_c_d    = win_c_q;
    win_r_d    = win_r_q;
    fill_d     = fill_q;
    kernel_d   = kernel_q;
    pend_d     = pend_q;
    pend_pix_d = pend_pix_q;
    pend_y_d   = pend_y_q;

    accept   = data_valid_in && (hcount_in <= X_LAST) && (vcount_in <= Y_LAST);
    // The first beat after reset only primes the window; it has no valid centre column.
    win_emit = accept && (hcount_in != '0) && fill_q;
    flush    = pend_q && !win_emit;

    if (accept) begin
      win_l_d = win_c_q;
      win_c_d = win_r_q;
      win_r_d = line_buffer_in;
      fill_d  = 1'b1;
      if (hcount_in == '0 && vcount_in == '0) kernel_d = kernel_select_in;
    end

    s0_valid_d  = win_emit || flush;
    s0_bypass_d = !win_emit;
    s0_x_d      = win_emit ? hcount_in - 11'd1 : X_LAST;
    s0_y_d      = win_emit ? vcount_in : pend_y_q;
    s0_pix_d    = pend_pix_q;

    if (flush) pend_d = 1'b0;
    if (accept && hcount_in == X_LAST) begin
      pend_d     = 1'b1;
      pend_pix_d = line_buffer_in[1];
      pend_y_d   = vcount_in;
    end
  end

  always_comb begin
    s1_valid_d = s0_valid_q;
    s1_x_d     = s0_x_q;
    s1_y_d     = s0_y_q;
    s1_pix_d   = s0_bypass_q ? s0_pix_q : win_c_q[1];
    border     = (s0_x_q == '0) || (s0_x_q == X_LAST) || (s0_y_q == '0) || (s0_y_q == Y_LAST);
    s1_kind_d  = K_PASS;
    if (!s0_bypass_q && !border) begin
      case (kernel_q)
        2'd1:    s1_kind_d = K_GAUSS;
        2'd2:    s1_kind_d = K_SHARP;
        default: s1_kind_d = K_PASS;
      endcase
    end
    s1_sum_d = '0;
    nw = '0; n = '0; ne = '0; w = '0; c = '0; e = '0; sw = '0; s = '0; se = '0;
    gsum = '0; ssum = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      nw = chan(win_l_q[2], k); n = chan(win_c_q[2], k); ne = chan(win_r_q[2], k);
      w  = chan(win_l_q[1], k); c = chan(win_c_q[1], k); e  = chan(win_r_q[1], k);
      sw = chan(win_l_q[0], k); s = chan(win_c_q[0], k); se = chan(win_r_q[0], k);
      gsum = 11'(nw) + 11'(ne) + 11'(sw) + 11'(se)
           + ((11'(n) + 11'(w) + 11'(e) + 11'(s)) << 1) + (11'(c) << 2);
      // Two's-complement wrap in 11 bits yields the signed sharpen result.
      ssum = (11'(c) << 2) + 11'(c) - 11'(n) - 11'(s) - 11'(e) - 11'(w);
      s1_sum_d[k] = (s1_kind_d == K_SHARP) ? ssum : gsum;
    end
  end

  always_comb begin
    valid_d  = s1_valid_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    pixel_d  = pixel_q;
    if (s1_valid_q) begin
      hcount_d = s1_x_q;
      vcount_d = s1_y_q;
      case (s1_kind_q)
        K_GAUSS: pixel_d = {s1_sum_q[2][8:4], s1_sum_q[1][9:4], s1_sum_q[0][8:4]};
        K_SHARP: pixel_d = {5'(clamp(s1_sum_q[2], 6'd31)), clamp(s1_sum_q[1], 6'd63),
                            5'(clamp(s1_sum_q[0], 6'd31))};
        default: pixel_d = s1_pix_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      win_l_q <= '0; win_c_q <= '0; win_r_q <= '0;
      fill_q <= 1'b0; kernel_q <= '0;
      pend_q <= 1'b0; pend_pix_q <= '0; pend_y_q <= '0;
      s0_valid_q <= 1'b0; s0_bypass_q <= 1'b0; s0_x_q <= '0; s0_y_q <= '0; s0_pix_q <= '0;
      s1_valid_q <= 1'b0; s1_kind_q <= K_PASS; s1_x_q <= '0; s1_y_q <= '0;
      s1_pix_q <= '0; s1_sum_q <= '0;
      pixel_q <= '0; hcount_q <= '0; vcount_q <= '0; valid_q <= 1'b0;
    end else begin
      win_l_q <= win_l_d; win_c_q <= win_c_d; win_r_q <= win_r_d;
      fill_q <= fill_d; kernel_q <= kernel_d;
      pend_q <= pend_d; pend_pix_q <= pend_pix_d; pend_y_q <= pend_y_d;
      s0_valid_q <= s0_valid_d; s0_bypass_q <= s0_bypass_d;
      s0_x_q <= s0_x_d; s0_y_q <= s0_y_d; s0_pix_q <= s0_pix_d;
      s1_valid_q <= s1_valid_d; s1_kind_q <= s1_kind_d; s1_x_q <= s1_x_d; s1_y_q <= s1_y_d;
      s1_pix_q <= s1_pix_d; s1_sum_q <= s1_sum_d;
      pixel_q <= pixel_d; hcount_q <= hcount_d; vcount_q <= vcount_d; valid_q <= valid_d;
    end
  end

  assign pixel_out      = pixel_q;
  assign hcount_out     = hcount_q;
  assign vcount_out     = vcount_q;
  assign data_valid_out = valid_q;
endmodule
